// File: rtl/hex_page_display_if.sv
// Signal bundle between the channel sources/switches and the paging display controller.
// The controller sits on the slave modport; the stimulus side drives through master.
interface hex_page_display_if #(
    parameter int unsigned N_CHAN = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DIGITS = 8
);
    localparam int unsigned NIB   = DATA_W / 4;
    localparam int unsigned PAGES = (NIB + DIGITS - 1) / DIGITS;
    localparam int unsigned SEL_W = $clog2(N_CHAN);
    localparam int unsigned PG_W  = (PAGES > 1) ? $clog2(PAGES) : 1;

    logic [N_CHAN*DATA_W-1:0] chan_data;
    logic [N_CHAN-1:0]        chan_valid;
    logic [SEL_W-1:0]         chan_sel;
    logic                     page_step;
    logic                     auto_mode;
    logic                     freeze;
    logic [DIGITS*4-1:0]      digit_out;
    logic [DIGITS-1:0]        digit_blank;
    logic [PG_W-1:0]          page_idx;
    logic                     stale;

    modport master (
        output chan_data, chan_valid, chan_sel, page_step, auto_mode, freeze,
        input  digit_out, digit_blank, page_idx, stale
    );

    modport slave (
        input  chan_data, chan_valid, chan_sel, page_step, auto_mode, freeze,
        output digit_out, digit_blank, page_idx, stale
    );
endinterface

// File: rtl/hex_page_display.sv
// Paging display controller: snapshots channel words on their strobes and shows the selected
// channel one page of hex digits at a time, stepped by button edge or a timed auto scroll.
module hex_page_display #(
    parameter int unsigned N_CHAN     = 4,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned SCROLL_DIV = 50_000_000
) (
    input logic               clk,
    input logic               rst,
    hex_page_display_if.slave bus
);
    localparam int unsigned NIB   = DATA_W / 4;
    localparam int unsigned PAGES = (NIB + DIGITS - 1) / DIGITS;
    localparam int unsigned SEL_W = $clog2(N_CHAN);
    localparam int unsigned PG_W  = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int unsigned CNT_W = $clog2(SCROLL_DIV);
    localparam int unsigned PAD_W = PAGES * DIGITS * 4;

    typedef enum logic [1:0] {StWait, StManual, StAuto} state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   snap_q [N_CHAN];
    logic [N_CHAN-1:0]   snap_ok_q;
    logic [SEL_W-1:0]    sel_q;
    logic [PG_W-1:0]     page_q;
    logic [CNT_W-1:0]    scroll_cnt_q;
    logic                step_q;

    logic                step_edge;
    logic                chan_change;
    logic                cur_ok;
    logic                new_ok;
    logic [DATA_W-1:0]   cur_word;
    logic [PAD_W-1:0]    padded;
    logic [DIGITS*4-1:0] page_word;
    logic [PG_W-1:0]     page_next;
    logic [DIGITS*4-1:0] digit_d;
    logic [DIGITS-1:0]   blank_d;
    logic                scroll_wrap;

    always_comb begin
        step_edge   = bus.page_step & ~step_q;
        chan_change = (bus.chan_sel != sel_q);
        cur_ok      = 1'b0;
        new_ok      = 1'b0;
        cur_word    = '0;
        // Selects with no matching channel fall through as "no snapshot".
        for (int unsigned i = 0; i < N_CHAN; i++) begin
            if (sel_q == SEL_W'(i)) begin
                cur_ok   = snap_ok_q[i];
                cur_word = snap_q[i];
            end
            if (bus.chan_sel == SEL_W'(i)) begin
                new_ok = snap_ok_q[i];
            end
        end
        page_next   = (page_q == PG_W'(PAGES - 1)) ? '0 : page_q + 1'b1;
        scroll_wrap = (scroll_cnt_q == CNT_W'(SCROLL_DIV - 1));

        padded              = '0;
        padded[DATA_W-1:0]  = cur_word;
        page_word           = padded[page_q * (DIGITS * 4) +: DIGITS * 4];
        digit_d             = '0;
        blank_d             = '1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if ((32'(page_q) * DIGITS + k < NIB) && (state_q != StWait)) begin
                digit_d[k*4 +: 4] = page_word[k*4 +: 4];
                blank_d[k]        = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_CHAN; i++) begin
                snap_q[i] <= '0;
            end
            snap_ok_q       <= '0;
            sel_q           <= '0;
            page_q          <= '0;
            scroll_cnt_q    <= '0;
            step_q          <= 1'b0;
            state_q         <= StWait;
            bus.digit_out   <= '0;
            bus.digit_blank <= '1;
            bus.page_idx    <= '0;
            bus.stale       <= 1'b1;
        end else begin
            step_q <= bus.page_step;
            for (int unsigned i = 0; i < N_CHAN; i++) begin
                if (bus.chan_valid[i] && !bus.freeze) begin
                    snap_q[i]    <= bus.chan_data[i*DATA_W +: DATA_W];
                    snap_ok_q[i] <= 1'b1;
                end
            end

            // A channel switch restarts the view and masks any step or scroll this cycle.
            if (chan_change) begin
                sel_q        <= bus.chan_sel;
                page_q       <= '0;
                scroll_cnt_q <= '0;
                if (!new_ok) begin
                    state_q <= StWait;
                end else if (state_q == StWait) begin
                    state_q <= bus.auto_mode ? StAuto : StManual;
                end
            end else begin
                unique case (state_q)
                    StWait: begin
                        page_q       <= '0;
                        scroll_cnt_q <= '0;
                        if (cur_ok) begin
                            state_q <= bus.auto_mode ? StAuto : StManual;
                        end
                    end
                    StManual: begin
                        if (step_edge) begin
                            page_q <= page_next;
                        end
                        if (bus.auto_mode) begin
                            state_q      <= StAuto;
                            scroll_cnt_q <= '0;
                        end
                    end
                    StAuto: begin
                        if (!bus.auto_mode) begin
                            state_q      <= StManual;
                            scroll_cnt_q <= '0;
                            if (step_edge) begin
                                page_q <= page_next;
                            end
                        end else if (step_edge || scroll_wrap) begin
                            page_q       <= page_next;
                            scroll_cnt_q <= '0;
                        end else begin
                            scroll_cnt_q <= scroll_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= StWait;
                endcase
            end

            bus.digit_out   <= digit_d;
            bus.digit_blank <= blank_d;
            bus.page_idx    <= page_q;
            bus.stale       <= (state_q == StWait);
        end
    end
endmodule

// File: tb/tb_hex_page_display.sv
// Directed bench for hex_page_display: a 64-bit and a 40-bit instance share clock and reset;
// expectations go into a scoreboard queue when stimulus is applied and are popped on sampling.
module tb_hex_page_display;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hex_page_display_if #(.N_CHAN(4), .DATA_W(64), .DIGITS(8)) bus ();
    hex_page_display_if #(.N_CHAN(4), .DATA_W(40), .DIGITS(8)) bus40 ();

    hex_page_display #(.N_CHAN(4), .DATA_W(64), .DIGITS(8), .SCROLL_DIV(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    hex_page_display #(.N_CHAN(4), .DATA_W(40), .DIGITS(8), .SCROLL_DIV(4)) u_dut40 (
        .clk (clk),
        .rst (rst),
        .bus (bus40.slave)
    );

    typedef struct {
        string       tag;
        int          which;
        logic        only_page;
        logic [41:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sb_push(input string tag, input int which, input logic [31:0] d,
                           input logic [7:0] b, input logic p, input logic s);
        sb.push_back('{tag, which, 1'b0, {d, b, p, s}});
    endtask

    task automatic sb_push_page(input string tag, input int which, input logic p);
        sb.push_back('{tag, which, 1'b1, {41'b0, p}});
    endtask

    task automatic sb_pop_check();
        exp_t        e;
        logic [41:0] obs;
        e = sb.pop_front();
        if (e.which == 0) obs = {bus.digit_out, bus.digit_blank, bus.page_idx, bus.stale};
        else              obs = {bus40.digit_out, bus40.digit_blank, bus40.page_idx, bus40.stale};
        if (e.only_page) obs = {41'b0, obs[1]};
        checks++;
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (digits,blank,page,stale)", e.tag, obs, e.exp);
        end
    endtask

    initial begin
        bus.chan_data = '0;  bus.chan_valid = '0;  bus.chan_sel = '0;
        bus.page_step = 0;   bus.auto_mode = 0;    bus.freeze = 0;
        bus40.chan_data = '0; bus40.chan_valid = '0; bus40.chan_sel = '0;
        bus40.page_step = 0;  bus40.auto_mode = 0;   bus40.freeze = 0;

        // Reset, no valids
        tick(2);
        sb_push("reset64", 0, 32'h0, 8'hFF, 1'b0, 1'b1);
        sb_push("reset40", 1, 32'h0, 8'hFF, 1'b0, 1'b1);
        sb_pop_check(); sb_pop_check();
        rst = 1'b1;

        // Load ch0 and check two-cycle latency
        bus.chan_data[63:0] = 64'h0123456789ABCDEF;
        bus.chan_valid = 4'b0001;
        tick(1);
        bus.chan_valid = 4'b0000;
        sb_push("latency_t1", 0, 32'h0, 8'hFF, 1'b0, 1'b1);
        tick(1); sb_pop_check();
        sb_push("load_ch0", 0, 32'h89ABCDEF, 8'h00, 1'b0, 1'b0);
        tick(1); sb_pop_check();

        bus.page_step = 1; tick(1); bus.page_step = 0;
        sb_push("step_p1", 0, 32'h01234567, 8'h00, 1'b1, 1'b0);
        tick(2); sb_pop_check();
        bus.page_step = 1; tick(1); bus.page_step = 0;
        sb_push("step_wrap", 0, 32'h89ABCDEF, 8'h00, 1'b0, 1'b0);
        tick(2); sb_pop_check();

        // Auto scroll: page flips every 4 cycles
        bus.auto_mode = 1;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) sb_push_page("auto_k4", 0, 1'b0);
            if (k == 5) sb_push_page("auto_k5", 0, 1'b1);
            if (k == 8) sb_push_page("auto_k8", 0, 1'b1);
            if (k == 9) sb_push_page("auto_k9", 0, 1'b0);
            tick(1);
            if (k == 4 || k == 5 || k == 8 || k == 9) sb_pop_check();
        end
        bus.auto_mode = 0;
        tick(1);

        // Held step advances exactly once
        bus.page_step = 1; tick(6); bus.page_step = 0;
        sb_push("step_held", 0, 32'h01234567, 8'h00, 1'b1, 1'b0);
        tick(2); sb_pop_check();
        bus.page_step = 1; tick(1); bus.page_step = 0;
        sb_push("step_back", 0, 32'h89ABCDEF, 8'h00, 1'b0, 1'b0);
        tick(2); sb_pop_check();

        // Freeze blocks the load
        bus.freeze = 1;
        bus.chan_data[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.chan_valid = 4'b0001;
        tick(1);
        bus.chan_valid = 4'b0000;
        sb_push("freeze_hold", 0, 32'h89ABCDEF, 8'h00, 1'b0, 1'b0);
        tick(3); sb_pop_check();
        bus.freeze = 0;
        sb_push("unfreeze_hold", 0, 32'h89ABCDEF, 8'h00, 1'b0, 1'b0);
        tick(3); sb_pop_check();

        // Channel change overrides a same-cycle step
        bus.chan_data[127:64] = 64'h133457799BBCDFF1;
        bus.chan_valid = 4'b0010;
        tick(1);
        bus.chan_valid = 4'b0000;
        bus.page_step = 1; tick(1); bus.page_step = 0;
        sb_push("ch0_page1", 0, 32'h01234567, 8'h00, 1'b1, 1'b0);
        tick(2); sb_pop_check();
        bus.chan_sel = 2'd1;
        bus.page_step = 1;
        sb_push("sel_ch1", 0, 32'h9BBCDFF1, 8'h00, 1'b0, 1'b0);
        tick(3); sb_pop_check();
        bus.page_step = 0;
        bus.chan_sel = 2'd2;
        sb_push("sel_empty", 0, 32'h0, 8'hFF, 1'b0, 1'b1);
        tick(2); sb_pop_check();

        // 40-bit instance: partial last page
        bus40.chan_data[39:0] = 40'hAB_CDEF_0123;
        bus40.chan_valid = 4'b0001;
        tick(1);
        bus40.chan_valid = 4'b0000;
        sb_push("w40_page0", 1, 32'hCDEF0123, 8'h00, 1'b0, 1'b0);
        tick(2); sb_pop_check();
        bus40.page_step = 1; tick(1); bus40.page_step = 0;
        sb_push("w40_page1", 1, 32'h000000AB, 8'hFC, 1'b1, 1'b0);
        tick(2); sb_pop_check();

        // Reset in the middle of auto scroll
        bus40.auto_mode = 1;
        tick(6);
        rst = 1'b0;
        sb_push("midreset40", 1, 32'h0, 8'hFF, 1'b0, 1'b1);
        sb_push("midreset64", 0, 32'h0, 8'hFF, 1'b0, 1'b1);
        tick(1); sb_pop_check(); sb_pop_check();
        rst = 1'b1;
        sb_push("postreset40", 1, 32'h0, 8'hFF, 1'b0, 1'b1);
        tick(2); sb_pop_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
